// File: rtl/uart_rx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Oversampling UART receiver (3-sample majority vote) feeding a
//            first-word-fall-through receive FIFO with per-entry status flags.
//            Define UART_RX_PARITY_EN to build parity checking and storage.
// Revision : 1.0
// ============================================================================
module uart_rx_fifo #(
  parameter int CLK_HZ       = 12000000,
  parameter int BIT_RATE     = 115200,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int OVERSAMPLE   = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        uart_rxd,
  input  logic                        rx_en,
  input  logic [1:0]                  parity_mode,
  output logic [PAYLOAD_BITS-1:0]     rd_data,
  output logic                        rd_frame_err,
  output logic                        rd_parity_err,
  output logic                        rd_break,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow
);

  localparam int DIV_RAW = (CLK_HZ + BIT_RATE * OVERSAMPLE / 2) / (BIT_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
  localparam int DIV_W   = $clog2(DIV);
  localparam int TICK_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W   = 4;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
`ifdef UART_RX_PARITY_EN
  localparam int ENTRY_W = PAYLOAD_BITS + 3;
`else
  localparam int ENTRY_W = PAYLOAD_BITS + 2;
`endif

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(OVERSAMPLE / 2);
  localparam logic [TICK_W-1:0] TICK_VOTE = TICK_W'(OVERSAMPLE / 2 + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              sync_q, sync_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [TICK_W-1:0]       tick_q, tick_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [1:0]              samp_q, samp_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    ferr_q, ferr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic [ENTRY_W-1:0]      mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]      mem_d [FIFO_DEPTH];

  logic               line_s, div_tick, at_vote, vote, frame_ferr, frame_brk;
  logic               push, pop, full, do_write;
  logic [ENTRY_W-1:0] push_entry, head;

  assign line_s     = sync_q[1];
  assign div_tick   = (state_q != IDLE) && (div_q == DIV_LAST);
  assign at_vote    = div_tick && (tick_q == TICK_VOTE);
  assign vote       = (samp_q[0] & samp_q[1]) | (samp_q[0] & line_s) | (samp_q[1] & line_s);
  assign frame_ferr = ferr_q | ~vote;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic parity_on, frame_perr;
  assign parity_on  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
  // Odd mode flips the sense of the XOR check; parity_mode[1] is set only for odd.
  assign frame_perr = parity_on & ((^shift_q) ^ par_q ^ parity_mode[1]);
  assign frame_brk  = frame_ferr && (shift_q == '0) && !(parity_on && par_q);
  assign push_entry = {frame_perr, frame_brk, frame_ferr, shift_q};
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
  assign frame_brk  = frame_ferr && (shift_q == '0);
  assign push_entry = {frame_brk, frame_ferr, shift_q};
`endif

  always_comb begin
    sync_d  = {sync_q[0], uart_rxd};
    state_d = state_q;
    bit_d   = bit_q;
    samp_d  = samp_q;
    shift_d = shift_q;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    push    = 1'b0;

    if (div_tick && (tick_q == TICK_S0)) samp_d[0] = line_s;
    if (div_tick && (tick_q == TICK_S1)) samp_d[1] = line_s;

    // State moves at the vote tick; the tick counter keeps bit boundaries.
    case (state_q)
      IDLE: begin
        if (!line_s) begin
          state_d = START;
          bit_d   = '0;
          ferr_d  = 1'b0;
        end
      end
      START: begin
        if (at_vote) state_d = vote ? IDLE : DATA;
      end
      DATA: begin
        if (at_vote) begin
          shift_d = {vote, shift_q[PAYLOAD_BITS-1:1]};
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = parity_on ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (at_vote) begin
          par_d   = vote;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (at_vote) begin
          ferr_d = frame_ferr;
          if (bit_q == STOP_LAST) begin
            push    = 1'b1;
            state_d = frame_ferr ? WAIT_HIGH : IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      WAIT_HIGH: begin
        if (line_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!rx_en) begin
      state_d = IDLE;
      push    = 1'b0;
    end

    if (state_d == IDLE) begin
      div_d  = '0;
      tick_d = '0;
    end else begin
      div_d  = div_tick ? '0 : div_q + DIV_W'(1);
      tick_d = tick_q;
      if (div_tick) tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
    end
  end

  assign rd_valid = (count_q != '0);
  assign pop      = rd_valid & rd_ready;
  assign full     = (count_q == LVL_FULL);
  // A pop in the same cycle frees the slot the write lands in.
  assign do_write = push & (~full | pop);

  always_comb begin
    mem_d = mem_q;
    if (do_write) mem_d[wr_ptr_q] = push_entry;
    wr_ptr_d   = do_write ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    overflow_d = overflow_q | (push & full & ~pop);
    count_d    = count_q;
    case ({do_write, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  assign head          = mem_q[rd_ptr_q];
  assign rd_data       = rd_valid ? head[PAYLOAD_BITS-1:0] : '0;
  assign rd_frame_err  = rd_valid & head[PAYLOAD_BITS];
  assign rd_break      = rd_valid & head[PAYLOAD_BITS+1];
`ifdef UART_RX_PARITY_EN
  assign rd_parity_err = rd_valid & head[PAYLOAD_BITS+2];
`else
  assign rd_parity_err = 1'b0;
`endif
  assign level    = count_q;
  assign overflow = overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sync_q     <= 2'b11;
      div_q      <= '0;
      tick_q     <= '0;
      bit_q      <= '0;
      samp_q     <= '0;
      shift_q    <= '0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
`endif
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      div_q      <= div_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
`endif
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// Testbench for uart_rx_fifo: directed scenarios plus random frames checked
// against a queue-based model of the receive FIFO.
module tb_uart_rx_fifo;

  localparam int CLK_HZ   = 12000000;
  localparam int BIT_RATE = 115200;
  localparam int OS       = 8;
  localparam int DEPTH    = 4;
  localparam int DIV      = (CLK_HZ + BIT_RATE * OS / 2) / (BIT_RATE * OS);
  localparam int BIT_CLKS = DIV * OS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       rx_en = 1'b0;
  logic       rd_ready = 1'b0;
  logic [1:0] parity_mode = 2'b00;
  logic [7:0] rd_data;
  logic       rd_frame_err, rd_parity_err, rd_break, rd_valid, overflow;
  logic [2:0] level;

  uart_rx_fifo #(
    .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(8),
    .STOP_BITS(1), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .rx_en(rx_en),
    .parity_mode(parity_mode), .rd_data(rd_data), .rd_frame_err(rd_frame_err),
    .rd_parity_err(rd_parity_err), .rd_break(rd_break), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       brk;
    logic       perr;
    logic       ferr;
    logic [7:0] data;
  } ent_t;

  ent_t exp_q[$];
  logic exp_ovf = 1'b0;
  int   tests = 0;
  int   fails = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic line_bit(input logic b);
    uart_rxd = b;
    step(BIT_CLKS);
  endtask

  // has_par: a parity bit is on the wire and the receiver is expected to check it
  task automatic frame(input logic [7:0] d, input bit has_par, input bit par,
                       input bit stop_ok, input bit odd);
    ent_t e;
    int   ones;
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(d[i]);
    if (has_par) line_bit(par);
    line_bit(stop_ok);
    uart_rxd = 1'b1;
    step(BIT_CLKS);
    ones   = $countones(d) + (has_par ? int'(par) : 0);
    e.data = d;
    e.ferr = !stop_ok;
    e.perr = has_par && ((ones % 2) != (odd ? 1 : 0));
    e.brk  = e.ferr && (d == 8'h00) && !(has_par && par);
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else exp_ovf = 1'b1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_level"}, level, exp_q.size());
    chk({tag, "_overflow"}, overflow, exp_ovf);
  endtask

  task automatic drain();
    ent_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("head", {rd_valid, rd_break, rd_parity_err, rd_frame_err, rd_data}, {1'b1, e});
      rd_ready = 1'b1;
      step(1);
      rd_ready = 1'b0;
      chk("level_after_pop", level, exp_q.size());
    end
    chk("empty", rd_valid, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    uart_rxd = 1'b1;
    step(2);
    reset = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    step(BIT_CLKS);
  endtask

  initial begin
    // reset state
    step(3);
    chk("rst_outputs", {rd_valid, rd_break, rd_parity_err, rd_frame_err, rd_data, overflow, level},
        '0);
    reset = 1'b0;
    rx_en = 1'b1;
    step(BIT_CLKS);

    // 8N1 0x55
    frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    check_state("f55");
    drain();

    // consumer ready on an empty FIFO changes nothing
    rd_ready = 1'b1;
    step(4);
    rd_ready = 1'b0;
    chk("ready_empty_level", level, 0);
    frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
    check_state("f81");
    drain();

    // long break: one entry only
    uart_rxd = 1'b0;
    step(20 * BIT_CLKS);
    uart_rxd = 1'b1;
    step(2 * BIT_CLKS);
    exp_q.push_back('{brk: 1'b1, perr: 1'b0, ferr: 1'b1, data: 8'h00});
    check_state("break");
    drain();

    // framing error on non-zero data is not a break
    frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(8'h3E, 1'b0, 1'b0, 1'b1, 1'b0);
    check_state("ferr");
    drain();

    // random bursts with no consumer
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++)
        frame(8'($urandom), 1'b0, 1'b0, ($urandom_range(0, 5) != 0), 1'b0);
      check_state("rand");
      drain();
    end

    // glitch of two ticks on an idle line
    uart_rxd = 1'b0;
    step(2 * DIV);
    uart_rxd = 1'b1;
    step(2 * BIT_CLKS);
    check_state("glitch");

    // receiver disabled mid-frame
    line_bit(1'b0);
    for (int i = 0; i < 3; i++) line_bit(1'(8'hC3 >> i));
    rx_en = 1'b0;
    step(2);
    uart_rxd = 1'b1;
    step(BIT_CLKS);
    rx_en = 1'b1;
    step(BIT_CLKS);
    check_state("abort");
    frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    // reset mid-DATA, then a clean frame
    line_bit(1'b0);
    for (int i = 0; i < 4; i++) line_bit(1'(8'h3C >> i));
    do_reset();
    check_state("mid_reset");
    frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    check_state("after_reset");
    drain();

    // overflow: five frames into four entries
    for (int k = 1; k <= 5; k++) frame(8'(k), 1'b0, 1'b0, 1'b1, 1'b0);
    check_state("ovf");
    drain();
    chk("ovf_sticky", overflow, 1'b1);
    do_reset();
    chk("ovf_cleared", overflow, 1'b0);

`ifdef UART_RX_PARITY_EN
    parity_mode = 2'b01;
    frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
    frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    check_state("even");
    drain();
    parity_mode = 2'b10;
    for (int k = 0; k < 4; k++) frame(8'($urandom), 1'b1, 1'($urandom), 1'b1, 1'b1);
    check_state("odd");
    drain();
`else
    parity_mode = 2'b01;
    frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("nopar");
    drain();
`endif
    parity_mode = 2'b00;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 12000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BIT_RATE, default 115200, line rate in bits/s.
REQ-003 The block SHALL have parameter PAYLOAD_BITS, default 8, data bits per frame, legal 5..9.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, stop bits checked per frame, legal 1..2.
REQ-005 The block SHALL have parameter OVERSAMPLE, default 8, sample ticks per bit, legal 4..16.
REQ-006 The block SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries, power of 2, minimum 2.
REQ-007 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-008 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 The block SHALL have port uart_rxd, input, 1, asynchronous serial line, idle high.
REQ-010 The block SHALL have port rx_en, input, 1, receiver enable.
REQ-011 The block SHALL have port parity_mode, input, 2: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-012 The block SHALL have port rd_data, output, PAYLOAD_BITS, FIFO head data.
REQ-013 The block SHALL have ports rd_frame_err, rd_parity_err and rd_break, each output, 1, FIFO head status flags.
REQ-014 The block SHALL have port rd_valid, output, 1, FIFO not empty.
REQ-015 The block SHALL have port rd_ready, input, 1, consumer accept.
REQ-016 The block SHALL have port level, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-017 The block SHALL have port overflow, output, 1, sticky dropped-frame flag.

Function
REQ-018 uart_rxd SHALL pass through a 2-flop synchroniser before any use.
REQ-019 The tick divider SHALL be DIV = (CLK_HZ + BIT_RATE*OVERSAMPLE/2) / (BIT_RATE*OVERSAMPLE), DIV >= 2; it SHALL produce a one-cycle tick every DIV clocks, and SHALL be held at zero in IDLE.
REQ-020 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-021 IDLE -> START SHALL occur when the synchronised line is 0 and rx_en=1.
REQ-022 Each bit SHALL be resolved by a majority vote of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit.
REQ-023 A START vote of 1 (glitch) SHALL return the FSM to IDLE with no FIFO push.
REQ-024 DATA SHALL collect PAYLOAD_BITS bits LSB first; PARITY SHALL be visited only when parity is enabled and not none.
REQ-025 rd_parity_err SHALL be set when the XOR of the data bits and the parity bit is 1 for even or 0 for odd.
REQ-026 A 0 vote on any stop bit SHALL set frame_err for that frame.
REQ-027 break SHALL equal frame_err AND data all-zero AND parity bit, if present, 0.
REQ-028 The frame SHALL complete at the vote tick of the last stop bit, pushing {break, parity_err, frame_err, data} in the same cycle.
REQ-029 After the push, the FSM SHALL go to IDLE if frame_err=0, else to WAIT_HIGH.
REQ-030 WAIT_HIGH SHALL hold until the synchronised line is 1, then go to IDLE; a long break SHALL yield exactly one entry.
REQ-031 rx_en=0 SHALL force the FSM to IDLE next cycle, abort any frame with no push, and leave the FIFO untouched.
REQ-032 A pushed entry SHALL be visible at rd_valid/rd_data on the next cycle; head outputs SHALL be first-word-fall-through.
REQ-033 A pop SHALL occur on rd_valid AND rd_ready; rd_ready with rd_valid=0 SHALL have no effect.
REQ-034 A push when level=FIFO_DEPTH with no pop in the same cycle SHALL drop the frame and set overflow; a simultaneous pop SHALL make the push succeed.
REQ-035 Simultaneous push and pop SHALL leave level unchanged; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-036 reset=1 SHALL set FSM IDLE, synchroniser flops 1, tick and bit counters 0, FIFO empty, rd_valid 0, level 0, overflow 0, rd_data 0, and all rd_* flags 0, at the next clk edge.
REQ-037 Reset mid-frame SHALL discard the partial frame; overflow SHALL be cleared only by reset.

Configuration
REQ-038 With UART_RX_PARITY_EN defined, parity_mode SHALL be honoured per REQ-024/025 and rd_parity_err SHALL be stored per entry.
REQ-039 Without UART_RX_PARITY_EN, parity_mode SHALL be ignored, the PARITY state and parity storage SHALL not be built, and rd_parity_err SHALL be tied 0.

Verification
REQ-040 Default params, 8N1 frame 0x55 at 115200 -> one entry: rd_data=0x55, all flags 0, level=1.
REQ-041 With macro set, parity_mode=01: frame 0xA5 with parity 0 -> rd_parity_err=0; the same frame with parity 1 -> rd_parity_err=1, data 0xA5.
REQ-042 Line low for 20 bit times, then high -> exactly one entry: data 0x00, frame_err=1, break=1.
REQ-043 Five frames 0x01..0x05 with rd_ready=0 -> level=4, overflow=1; popping returns 0x01..0x04, and overflow stays 1.
REQ-044 A low pulse of 2 ticks on an idle line -> no entry; reset asserted mid-DATA of 0x3C, then a clean frame 0x3C -> level=1, data 0x3C.
